id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands and control each cycle; drives ALU inputs A, B and the 4-bit aluop.
- Resolves data hazards: EX/MEM and MEM/WB forwarding, write-back capture bypass, load-use bubble insertion, downstream hold and branch flush.

Parameters:
DW, 32, datapath width
RW, 5, register address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs_addr  in  RW  source register rs
id_rt_addr  in  RW  source register rt
id_rd_addr  in  RW  destination register
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rs_data  in  DW  register-file rs value
id_rt_data  in  DW  register-file rt value
id_imm  in  DW  extended immediate
id_alusrc  in  1  1: B = immediate, 0: B = rt
id_aluop  in  4  ALU opcode (0101 add, 0110 sub, 1001 clear, ...)
id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control
exmem_regwrite  in  1  MEM-stage writes a register
exmem_rd  in  RW  MEM-stage destination
exmem_result  in  DW  MEM-stage ALU result
memwb_regwrite  in  1  WB-stage writes a register
memwb_rd  in  RW  WB-stage destination
memwb_result  in  DW  WB-stage write data
ex_ready  in  1  downstream accepts; 0 = hold
flush  in  1  kill the decode-slot instruction
alu_a  out  DW  ALU operand A
alu_b  out  DW  ALU operand B
alu_op  out  4  ALU opcode
ex_valid  out  1  EX stage holds a real instruction
ex_rd  out  RW  EX destination
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control
ex_store_data  out  DW  forwarded rt for stores
stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n=0 at edge):
  - All registers cleared; ex_valid=0; control outputs 0.
  - alu_op=4'b1001 (clear); alu_a=alu_b=ex_store_data=0.
- Capture bypass:
  - At the capture edge, if memwb_regwrite and memwb_rd==id_rs_addr and memwb_rd!=0, latch memwb_result instead of id_rs_data.
  - Same rule for rt.
- Edge priority, highest first:
  - reset
  - ex_ready=0: hold all registers
  - flush=1: load bubble
  - load_use=1: load bubble
  - otherwise: load decode slot (a slot with id_valid=0 also loads as a bubble)
- Bubble contents: ex_valid=0, all control 0, alu_op=1001.
- flush while ex_ready=0 has no effect; the issuer holds flush until ex_ready=1.
- load_use (combinational) is 1 when all of the following hold:
  - ex_valid, ex_memread and id_valid
  - ex_rd!=0
  - (id_use_rs and ex_rd==id_rs_addr) or (id_use_rt and ex_rd==id_rt_addr)
- stall = ~ex_ready | (load_use & ~flush).
- Output forwarding (combinational, applied to registered rs/rt values):
  - Priority: EX/MEM over MEM/WB over registered value.
  - A source is eligible only if its regwrite=1, its rd equals the operand address, and that address is nonzero.
  - Register 0 always reads the registered value.
- Operand outputs:
  - alu_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_b = id_alusrc(registered) ? imm : forwarded rt.
- Latency: decode to ALU inputs is 1 cycle.
- A load-use dependency costs exactly 1 bubble; the dependent instruction enters EX on the following edge, taking the load value via MEM/WB forwarding.
- Arithmetic: none in this block; widths pass through unchanged.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: EX/MEM and MEM/WB output forwarding as above.
- Undefined:
  - alu_a/alu_b/ex_store_data use registered values only.
  - The hazard term widens to any RAW match against a valid EX-stage regwrite (ex_rd) or exmem_regwrite (exmem_rd), nonzero register only.
  - stall = ~ex_ready | (raw & ~flush); a bubble is inserted each stalled cycle.
  - The capture bypass remains in both builds.

Test Plan:
- Reset: rst_n=0 one edge → ex_valid=0, alu_op=1001, alu_a=alu_b=0, stall=0 (ex_ready=1).
- Plain issue: rs=3 (data 5), imm=7, alusrc=1, aluop=0101 → next cycle alu_a=5, alu_b=7, alu_op=0101, ex_valid=1.
- Forward priority: EX rs=4, exmem_rd=4 result 0x11, memwb_rd=4 result 0x22 → alu_a=0x11; with exmem_regwrite=0 → alu_a=0x22; rs=0 with both matching 0 → registered value.
- Load-use: EX holds lw to r8, decode add r9,r8,r1 → stall=1 one cycle, bubble (ex_valid=0, alu_op=1001), then add in EX with alu_a=memwb_result.
- Hold/flush: ex_ready=0 for 3 cycles → outputs frozen, stall=1; flush=1 with ex_ready=1 → next ex_valid=0; flush during load_use → stall=0.
- IDEX_FORWARD_EN undefined: dependent add r2 after add r2 → stall=1 for 2 cycles, correct operand after.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register feeding the ALU: capture bypass, hazard bubbles, hold and flush.
// Define IDEX_FORWARD_EN for EX/MEM and MEM/WB operand forwarding; otherwise RAW hazards stall.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  input  logic          ex_ready,
  input  logic          flush,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic [DW-1:0] ex_store_data,
  output logic          stall
);

  localparam logic [3:0] OP_CLEAR = 4'b1001;

  logic          ex_valid_reg;
  logic [RW-1:0] ex_rd_reg;
  logic          ex_regwrite_reg;
  logic          ex_memread_reg;
  logic          ex_memwrite_reg;
  logic          ex_memtoreg_reg;
  logic [DW-1:0] imm_reg;
  logic          alusrc_reg;
  logic [3:0]    aluop_reg;
  logic [DW-1:0] src_val_reg [2];
`ifdef IDEX_FORWARD_EN
  logic [RW-1:0] src_addr_reg [2];
`else
  logic          exmem_hit [2];
`endif

  // Index 0 is rs, index 1 is rt throughout.
  logic [RW-1:0] id_addr     [2];
  logic [DW-1:0] id_data     [2];
  logic          id_use      [2];
  logic [DW-1:0] capture_val [2];
  logic [DW-1:0] fwd_val     [2];
  logic          ex_hit      [2];

  logic hazard;
  logic load_slot;
  logic clear_slot;

  assign id_addr[0] = id_rs_addr;
  assign id_addr[1] = id_rt_addr;
  assign id_data[0] = id_rs_data;
  assign id_data[1] = id_rt_data;
  assign id_use[0]  = id_use_rs;
  assign id_use[1]  = id_use_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Write-back lands in the register file this same edge, so take it directly.
      assign capture_val[gi] = (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_addr[gi]))
                               ? memwb_result : id_data[gi];
      assign ex_hit[gi] = id_use[gi] && (id_addr[gi] == ex_rd_reg);
`ifdef IDEX_FORWARD_EN
      assign fwd_val[gi] =
        (exmem_regwrite && (src_addr_reg[gi] != '0) && (exmem_rd == src_addr_reg[gi])) ? exmem_result :
        (memwb_regwrite && (src_addr_reg[gi] != '0) && (memwb_rd == src_addr_reg[gi])) ? memwb_result :
        src_val_reg[gi];
`else
      assign fwd_val[gi]   = src_val_reg[gi];
      assign exmem_hit[gi] = id_use[gi] && (id_addr[gi] == exmem_rd);
`endif
    end
  endgenerate

`ifdef IDEX_FORWARD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = ex_valid_reg && ex_memread_reg && id_valid && (ex_rd_reg != '0) &&
                  (ex_hit[0] || ex_hit[1]);
`else
  // Without forwarding, any producer still in EX or MEM blocks the reader.
  assign hazard = id_valid &&
                  ((ex_valid_reg && ex_regwrite_reg && (ex_rd_reg != '0) && (ex_hit[0] || ex_hit[1])) ||
                   (exmem_regwrite && (exmem_rd != '0) && (exmem_hit[0] || exmem_hit[1])));
  wire unused_exmem_result = ^exmem_result;
`endif

  assign stall      = ~ex_ready | (hazard & ~flush);
  assign load_slot  = ex_ready & ~flush & ~hazard & id_valid;
  assign clear_slot = ~rst_n | (ex_ready & ~load_slot);

  always_ff @(posedge clk) begin
    if (clear_slot) begin
      ex_valid_reg    <= 1'b0;
      ex_rd_reg       <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
      ex_memtoreg_reg <= 1'b0;
      imm_reg         <= '0;
      alusrc_reg      <= 1'b0;
      aluop_reg       <= OP_CLEAR;
      for (int i = 0; i < 2; i++) begin
        src_val_reg[i]  <= '0;
`ifdef IDEX_FORWARD_EN
        src_addr_reg[i] <= '0;
`endif
      end
    end else if (load_slot) begin
      ex_valid_reg    <= 1'b1;
      ex_rd_reg       <= id_rd_addr;
      ex_regwrite_reg <= id_regwrite;
      ex_memread_reg  <= id_memread;
      ex_memwrite_reg <= id_memwrite;
      ex_memtoreg_reg <= id_memtoreg;
      imm_reg         <= id_imm;
      alusrc_reg      <= id_alusrc;
      aluop_reg       <= id_aluop;
      for (int i = 0; i < 2; i++) begin
        src_val_reg[i]  <= capture_val[i];
`ifdef IDEX_FORWARD_EN
        src_addr_reg[i] <= id_addr[i];
`endif
      end
    end
  end

  assign alu_a         = fwd_val[0];
  assign ex_store_data = fwd_val[1];
  assign alu_b         = alusrc_reg ? imm_reg : fwd_val[1];
  assign alu_op        = aluop_reg;
  assign ex_valid      = ex_valid_reg;
  assign ex_rd         = ex_rd_reg;
  assign ex_regwrite   = ex_regwrite_reg;
  assign ex_memread    = ex_memread_reg;
  assign ex_memwrite   = ex_memwrite_reg;
  assign ex_memtoreg   = ex_memtoreg_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed hazard scenarios plus random traffic against a
// behavioural EX-slot model. Honours IDEX_FORWARD_EN the same way as the design.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_alusrc;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_aluop;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_ready, flush;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, stall;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_ready(ex_ready), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_store_data(ex_store_data), .stall(stall)
  );

  // Reference: what instruction the EX slot holds.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd, rs, rt;
    logic [31:0] rs_val, rt_val, imm;
    logic        alusrc;
    logic [3:0]  op;
    logic        rw, mr, mw, mt;
  } slot_t;

  slot_t m;

  function automatic slot_t bubble();
    slot_t b = '0;
    b.op = 4'b1001;
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Does the decode-slot instruction read register r (r0 never counts)?
  function automatic logic reads(input logic [4:0] r);
    return id_valid && (r != 0) &&
           ((id_use_rs && id_rs_addr == r) || (id_use_rt && id_rt_addr == r));
  endfunction

  function automatic logic [31:0] captured(input logic [4:0] a, input logic [31:0] d);
    return (memwb_regwrite && a != 0 && memwb_rd == a) ? memwb_result : d;
  endfunction

`ifdef IDEX_FORWARD_EN
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
    if (a != 0 && exmem_regwrite && exmem_rd == a) return exmem_result;
    if (a != 0 && memwb_regwrite && memwb_rd == a) return memwb_result;
    return v;
  endfunction
`endif

  // Inputs are already set (just after a falling edge): compare, then advance over one rising edge.
  task automatic cycle();
    logic [31:0] ea, es, eb;
    logic haz;
    #1;
`ifdef IDEX_FORWARD_EN
    ea  = fwd(m.rs, m.rs_val);
    es  = fwd(m.rt, m.rt_val);
    haz = m.valid && m.mr && reads(m.rd);
`else
    ea  = m.rs_val;
    es  = m.rt_val;
    haz = (m.valid && m.rw && reads(m.rd)) || (exmem_regwrite && reads(exmem_rd));
`endif
    eb = m.alusrc ? m.imm : es;
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("store_data", ex_store_data, es);
    check("alu_op", alu_op, m.op);
    check("ex_valid", ex_valid, m.valid);
    check("ex_rd", ex_rd, m.rd);
    check("ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, {m.rw, m.mr, m.mw, m.mt});
    check("stall", stall, !ex_ready || (haz && !flush));
    $display("cyc %0d rst_n=%b rdy=%b fl=%b v=%b op=%h a=%h b=%h st=%b", cyc, rst_n, ex_ready,
             flush, ex_valid, alu_op, alu_a, alu_b, stall);
    @(posedge clk);
    if (!rst_n) m = bubble();
    else if (ex_ready) begin
      if (flush || haz || !id_valid) m = bubble();
      else begin
        m.valid  = 1'b1;
        m.rd     = id_rd_addr;
        m.rs     = id_rs_addr;
        m.rt     = id_rt_addr;
        m.rs_val = captured(id_rs_addr, id_rs_data);
        m.rt_val = captured(id_rt_addr, id_rt_data);
        m.imm    = id_imm;
        m.alusrc = id_alusrc;
        m.op     = id_aluop;
        {m.rw, m.mr, m.mw, m.mt} = {id_regwrite, id_memread, id_memwrite, id_memtoreg};
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_alusrc = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_aluop = 4'b0101;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg} = 4'b0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic mr);
    id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_alusrc = mr;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'h4;
    id_aluop = 4'b0101; id_regwrite = 1; id_memread = mr; id_memtoreg = mr; id_memwrite = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    m = bubble();
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", ex_valid, 1'b0);
    check("rst_op", alu_op, 4'b1001);
    check("rst_a", alu_a, 32'h0);
    check("rst_b", alu_b, 32'h0);
    check("rst_stall", stall, 1'b0);
    cycle();
    rst_n = 1;

    // Plain issue: rs=3 holds 5, immediate 7.
    idle(); id_valid = 1; id_use_rs = 1; id_rs_addr = 3; id_rs_data = 5;
    id_imm = 7; id_alusrc = 1; id_rd_addr = 6; id_regwrite = 1;
    cycle();
    idle(); #1;
    check("issue_a", alu_a, 32'd5);
    check("issue_b", alu_b, 32'd7);
    check("issue_op", alu_op, 4'b0101);
    check("issue_valid", ex_valid, 1'b1);
    cycle();

    // Forwarding priority while EX is held.
    idle(); instr(4, 0, 7, 32'h44, 32'h0, 0); cycle();
    idle(); ex_ready = 0;
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'h22;
`ifdef IDEX_FORWARD_EN
    #1 check("fwd_exmem", alu_a, 32'h11);
`endif
    cycle();
    exmem_regwrite = 0;
`ifdef IDEX_FORWARD_EN
    #1 check("fwd_memwb", alu_a, 32'h22);
`endif
    cycle();
    idle(); instr(0, 0, 7, 32'h33, 32'h0, 0); cycle();
    idle(); ex_ready = 0;
    exmem_regwrite = 1; memwb_regwrite = 1; exmem_result = 32'h11; memwb_result = 32'h22;
    #1 check("fwd_r0", alu_a, 32'h33);
    cycle();

    // Load-use: lw r8 then add r9,r8,r1.
    idle(); instr(2, 0, 8, 32'h100, 32'h0, 1); cycle();
    idle(); instr(8, 1, 9, 32'hdead, 32'h1, 0);
    #1 check("lu_stall", stall, 1'b1);
    cycle();
    check("lu_bubble_v", ex_valid, 1'b0);
    check("lu_bubble_op", alu_op, 4'b1001);
    exmem_regwrite = 1; exmem_rd = 8; exmem_result = 32'h104;
    cycle();
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'habc;
    cycle();
    idle(); memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'habc;
    cycle();
    idle(); cycle();

    // Hold for three cycles with random decode contents, then flush.
    idle(); instr(1, 2, 3, 32'h55, 32'h66, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd4, $urandom, $urandom, 0);
      ex_ready = 0;
      flush = (i == 1);
      cycle();
    end
    ex_ready = 1; flush = 1; cycle();
    check("flush_valid", ex_valid, 1'b0);

    // Flush during a load-use dependency must not stall.
    idle(); instr(2, 0, 8, 32'h100, 32'h0, 1); cycle();
    idle(); instr(8, 1, 9, 32'h5, 32'h1, 0); flush = 1;
    #1 check("flush_lu_stall", stall, 1'b0);
    cycle();

`ifndef IDEX_FORWARD_EN
    // Back-to-back producer/consumer on r2 costs two bubbles.
    idle(); instr(1, 0, 2, 32'h10, 32'h0, 0); cycle();
    idle(); instr(2, 0, 5, 32'h0, 32'h0, 0);
    #1 check("raw_stall1", stall, 1'b1);
    cycle();
    exmem_regwrite = 1; exmem_rd = 2; exmem_result = 32'h14;
    #1 check("raw_stall2", stall, 1'b1);
    cycle();
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_rd = 2; memwb_result = 32'h14;
    #1 check("raw_go", stall, 1'b0);
    cycle();
    idle(); #1 check("raw_operand", alu_a, 32'h14);
    cycle();
`endif

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 500; i++) begin
      rst_n          = ($urandom_range(0, 49) != 0);
      id_valid       = ($urandom_range(0, 4) != 0);
      id_rs_addr     = 5'($urandom_range(0, 3));
      id_rt_addr     = 5'($urandom_range(0, 3));
      id_rd_addr     = 5'($urandom_range(0, 3));
      id_use_rs      = 1'($urandom);
      id_use_rt      = 1'($urandom);
      id_rs_data     = $urandom;
      id_rt_data     = $urandom;
      id_imm         = $urandom;
      id_alusrc      = 1'($urandom);
      id_aluop       = 4'($urandom);
      id_regwrite    = 1'($urandom);
      id_memread     = 1'($urandom);
      id_memwrite    = 1'($urandom);
      id_memtoreg    = 1'($urandom);
      exmem_regwrite = 1'($urandom);
      exmem_rd       = 5'($urandom_range(0, 3));
      exmem_result   = $urandom;
      memwb_regwrite = 1'($urandom);
      memwb_rd       = 5'($urandom_range(0, 3));
      memwb_result   = $urandom;
      ex_ready       = ($urandom_range(0, 9) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
